// File: rtl/ctrl_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_stage_pkg
// Brief    : Opcode, ALU-op and immediate-select codes shared by the decoder.
// Revision : 1.0
// ============================================================================
package ctrl_decode_stage_pkg;

  localparam int ALUOP_WIDTH  = 4;
  localparam int IMMSEL_WIDTH = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [ALUOP_WIDTH-1:0] ALU_MEM    = 4'b0000;
  localparam logic [ALUOP_WIDTH-1:0] ALU_BRANCH = 4'b0001;
  localparam logic [ALUOP_WIDTH-1:0] ALU_REG    = 4'b0010;
  localparam logic [ALUOP_WIDTH-1:0] ALU_IMM    = 4'b0011;
  localparam logic [ALUOP_WIDTH-1:0] ALU_LUI    = 4'b0100;
  localparam logic [ALUOP_WIDTH-1:0] ALU_AUIPC  = 4'b0101;
  localparam logic [ALUOP_WIDTH-1:0] ALU_CSR    = 4'b0110;
  localparam logic [ALUOP_WIDTH-1:0] ALU_JUMP   = 4'b0111;

  localparam logic [IMMSEL_WIDTH-1:0] IMM_I = 3'b000;
  localparam logic [IMMSEL_WIDTH-1:0] IMM_S = 3'b001;
  localparam logic [IMMSEL_WIDTH-1:0] IMM_U = 3'b010;
  localparam logic [IMMSEL_WIDTH-1:0] IMM_B = 3'b011;
  localparam logic [IMMSEL_WIDTH-1:0] IMM_J = 3'b100;

  // Field order mirrors instr[31:7] so the slice can be assigned directly.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
  } fields_t;

  typedef struct packed {
    logic [ALUOP_WIDTH-1:0]  alu_op;
    logic                    alu_src;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic [IMMSEL_WIDTH-1:0] imm_sel;
    logic                    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode_table.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_table
// Brief    : Combinational RV32 opcode to control-bundle table.
//            CSR decode of SYSTEM (funct3 != 0) enabled by CTRL_CSR_EN.
// Revision : 1.0
// ============================================================================
module ctrl_decode_table
  import ctrl_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output fields_t     fields,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  assign fields = instr[31:7];

  always_comb begin
    ctrl     = CTRL_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        ctrl.alu_op    = ALU_REG;
        ctrl.reg_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_op    = ALU_IMM;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.imm_sel   = IMM_I;
        uses_rs1       = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl.alu_op    = (instr[6:0] == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.imm_sel   = IMM_U;
      end
      OPC_JAL: begin
        ctrl.alu_op    = ALU_JUMP;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.imm_sel   = IMM_J;
      end
      OPC_JALR: begin
        ctrl.alu_op    = ALU_JUMP;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.imm_sel   = IMM_I;
        uses_rs1       = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_op  = ALU_BRANCH;
        ctrl.imm_sel = IMM_B;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_op     = ALU_MEM;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.imm_sel    = IMM_I;
        uses_rs1        = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_op    = ALU_MEM;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.imm_sel   = IMM_S;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
`ifdef CTRL_CSR_EN
      OPC_SYSTEM: begin
        // funct3 == 0 is ECALL/EBREAK territory, which this stage does not support
        if (instr[14:12] != 3'b000) begin
          ctrl.alu_op    = ALU_CSR;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          uses_rs1       = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
`endif
      default: ctrl.illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_stage
// Brief    : Registered decode stage with valid/ready, flush and load-use bubble.
//            Optional CSR decode enabled by defining CTRL_CSR_EN.
// Revision : 1.0
// ============================================================================
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = ctrl_decode_stage_pkg::ALUOP_WIDTH,
  parameter int IMMSEL_W = ctrl_decode_stage_pkg::IMMSEL_WIDTH,
  parameter int CNT_W    = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALUOP_W-1:0]  out_alu_op,
  output logic                out_alu_src,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic                out_mem_to_reg,
  output logic [IMMSEL_W-1:0] out_imm_sel,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    stall_cnt
);

  ctrl_t   dec_ctrl;
  fields_t dec_fields;
  logic    dec_uses_rs1;
  logic    dec_uses_rs2;

  ctrl_decode_table u_table (
    .instr    (in_instr),
    .ctrl     (dec_ctrl),
    .fields   (dec_fields),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  ctrl_t            ctrl_q, ctrl_d;
  fields_t          fields_q, fields_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic load_en;
  logic accept;

  always_comb begin
    hazard  = in_valid && valid_q && ctrl_q.mem_read && (fields_q.rd != 5'd0) &&
              ((dec_uses_rs1 && (dec_fields.rs1 == fields_q.rd)) ||
               (dec_uses_rs2 && (dec_fields.rs2 == fields_q.rd)));
    load_en = (!valid_q || out_ready) && !flush;
    accept  = in_valid && load_en && !hazard;

    valid_d  = valid_q;
    pc_d     = pc_q;
    ctrl_d   = ctrl_q;
    fields_d = fields_q;
    // Bubbles and flushes also clear the bundle so no stale control can leak downstream
    if (flush || (load_en && !accept)) begin
      valid_d  = 1'b0;
      pc_d     = '0;
      ctrl_d   = CTRL_NONE;
      fields_d = '0;
    end else if (accept) begin
      valid_d  = 1'b1;
      pc_d     = in_pc;
      ctrl_d   = dec_ctrl;
      fields_d = dec_fields;
    end

    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      ctrl_q      <= CTRL_NONE;
      fields_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
      fields_q    <= fields_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready       = load_en && !hazard;
  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_alu_op     = ctrl_q.alu_op;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_imm_sel    = ctrl_q.imm_sel;
  assign out_illegal    = ctrl_q.illegal;
  assign out_rd         = fields_q.rd;
  assign out_rs1        = fields_q.rs1;
  assign out_rs2        = fields_q.rs2;
  assign out_funct3     = fields_q.funct3;
  assign out_funct7     = fields_q.funct7;
  assign stall_cnt      = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_decode_stage
// Brief    : Self-checking bench for ctrl_decode_stage (honours CTRL_CSR_EN).
// Revision : 1.0
// ============================================================================
module tb_ctrl_decode_stage;

`ifdef CTRL_CSR_EN
  localparam bit CSR_ON = 1'b1;
`else
  localparam bit CSR_ON = 1'b0;
`endif
  localparam int STALL_MAX = 65535;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  imm_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        illegal;
  } bnd_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_alu_op;
  logic        out_alu_src;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_mem_to_reg;
  logic [2:0]  out_imm_sel;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_illegal;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  ctrl_decode_stage dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_alu_op     (out_alu_op),
    .out_alu_src    (out_alu_src),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_mem_to_reg (out_mem_to_reg),
    .out_imm_sel    (out_imm_sel),
    .out_rd         (out_rd),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_funct3     (out_funct3),
    .out_funct7     (out_funct7),
    .out_illegal    (out_illegal),
    .stall_cnt      (stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference decode: what EX must see for one instruction, straight from the opcode rules.
  function automatic bnd_t golden(input logic [31:0] ins, input logic [31:0] pc);
    bnd_t b;
    b        = '0;
    b.pc     = pc;
    b.rd     = ins[11:7];
    b.rs1    = ins[19:15];
    b.rs2    = ins[24:20];
    b.funct3 = ins[14:12];
    b.funct7 = ins[31:25];
    case (ins[6:0])
      7'b0110011: begin b.alu_op = 4'd2; b.reg_write = 1'b1; end
      7'b0010011: begin b.alu_op = 4'd3; b.alu_src = 1'b1; b.reg_write = 1'b1; b.imm_sel = 3'd0; end
      7'b0110111: begin b.alu_op = 4'd4; b.alu_src = 1'b1; b.reg_write = 1'b1; b.imm_sel = 3'd2; end
      7'b0010111: begin b.alu_op = 4'd5; b.alu_src = 1'b1; b.reg_write = 1'b1; b.imm_sel = 3'd2; end
      7'b1101111: begin b.alu_op = 4'd7; b.alu_src = 1'b1; b.reg_write = 1'b1; b.imm_sel = 3'd4; end
      7'b1100111: begin b.alu_op = 4'd7; b.alu_src = 1'b1; b.reg_write = 1'b1; b.imm_sel = 3'd0; end
      7'b1100011: begin b.alu_op = 4'd1; b.imm_sel = 3'd3; end
      7'b0000011: begin
        b.alu_op = 4'd0; b.alu_src = 1'b1; b.reg_write = 1'b1;
        b.mem_read = 1'b1; b.mem_to_reg = 1'b1; b.imm_sel = 3'd0;
      end
      7'b0100011: begin b.alu_op = 4'd0; b.alu_src = 1'b1; b.mem_write = 1'b1; b.imm_sel = 3'd1; end
      7'b1110011: begin
        if (CSR_ON && ins[14:12] != 3'd0) begin
          b.alu_op = 4'd6; b.alu_src = 1'b1; b.reg_write = 1'b1;
        end else begin
          b.illegal = 1'b1;
        end
      end
      default: b.illegal = 1'b1;
    endcase
    if (b.rd == 5'd0) b.reg_write = 1'b0;
    return b;
  endfunction

  function automatic logic reads_rs1(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
           (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b1100111) ||
           (CSR_ON && op == 7'b1110011 && ins[14:12] != 3'd0);
  endfunction

  function automatic logic reads_rs2(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
  endfunction

  logic m_valid;
  bnd_t m_b;
  int   m_stall;

  function automatic logic model_hazard();
    return in_valid && m_valid && m_b.mem_read && (m_b.rd != 5'd0) &&
           ((reads_rs1(in_instr) && in_instr[19:15] == m_b.rd) ||
            (reads_rs2(in_instr) && in_instr[24:20] == m_b.rd));
  endfunction

  function automatic logic model_ready();
    return !flush && (!m_valid || out_ready) && !model_hazard();
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_valid <= 1'b0;
      m_b     <= '0;
      m_stall <= 0;
    end else begin
      if (model_hazard() && m_stall < STALL_MAX) m_stall <= m_stall + 1;
      if (flush) begin
        m_valid <= 1'b0;
      end else if (!m_valid || out_ready) begin
        if (in_valid && !model_hazard()) begin
          m_valid <= 1'b1;
          m_b     <= golden(in_instr, in_pc);
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  bnd_t act;
  assign act = {out_pc, out_alu_op, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                out_mem_to_reg, out_imm_sel, out_rd, out_rs1, out_rs2, out_funct3,
                out_funct7, out_illegal};

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    lit("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    lit("model_in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    lit("model_stall_cnt", {16'd0, stall_cnt}, m_stall);
    if (m_valid) begin
      checks++;
      if (act !== m_b) begin
        errors++;
        $display("FAIL model_bundle actual=%h required=%h at %0t", act, m_b, $time);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFFF_FFFF;
    in_pc     = 32'hA5A5_A5A5;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    lit("rst_valid", {31'd0, out_valid}, 32'd0);
    lit("rst_pc", out_pc, 32'd0);
    lit("rst_ctrl", {19'd0, out_alu_op, out_alu_src, out_reg_write, out_mem_read,
                     out_mem_write, out_mem_to_reg, out_imm_sel, out_illegal}, 32'd0);
    lit("rst_fields", {5'd0, out_rd, out_rs1, out_rs2, out_funct3, out_funct7}, 32'd0);
    lit("rst_stall", {16'd0, stall_cnt}, 32'd0);
    sys_rst_n = 1'b1;
    in_valid  = 1'b0;

    // addi x1,x0,5
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    lit("addi_valid", {31'd0, out_valid}, 32'd1);
    lit("addi_alu_op", {28'd0, out_alu_op}, 32'd3);
    lit("addi_alu_src", {31'd0, out_alu_src}, 32'd1);
    lit("addi_reg_write", {31'd0, out_reg_write}, 32'd1);
    lit("addi_rd", {27'd0, out_rd}, 32'd1);
    lit("addi_pc", out_pc, 32'h100);

    // lw x5,0(x1) followed by dependent add x6,x5,x2
    drive(1'b1, 32'h0000_A283, 32'h104, 1'b1, 1'b0);
    lit("lw_mem_read", {31'd0, out_mem_read}, 32'd1);
    lit("lw_mem_to_reg", {31'd0, out_mem_to_reg}, 32'd1);
    lit("lw_rd", {27'd0, out_rd}, 32'd5);
    in_instr = 32'h0022_8333;
    in_pc    = 32'h108;
    #1;
    lit("lu_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge sys_clk);
    #1;
    lit("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
    lit("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    lit("lu_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge sys_clk);
    #1;
    lit("lu_add_valid", {31'd0, out_valid}, 32'd1);
    lit("lu_add_alu_op", {28'd0, out_alu_op}, 32'd2);
    lit("lu_add_pc", out_pc, 32'h108);

    // Back-pressure: bundle held while EX stalls
    drive(1'b1, 32'h0050_0093, 32'h200, 1'b1, 1'b0);
    in_instr  = 32'h0020_8133;
    in_pc     = 32'h204;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk);
      #1;
      lit("hold_pc", out_pc, 32'h200);
      lit("hold_valid", {31'd0, out_valid}, 32'd1);
      lit("hold_in_ready", {31'd0, in_ready}, 32'd0);
      lit("hold_stall", {16'd0, stall_cnt}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    lit("release_pc", out_pc, 32'h204);

    // Flush beats a simultaneous accept
    drive(1'b1, 32'h0050_0093, 32'h300, 1'b1, 1'b1);
    lit("flush_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 32'h0050_0093, 32'h300, 1'b1, 1'b0);
    lit("flush_not_captured", {31'd0, out_valid}, 32'd0);

    drive(1'b1, 32'h0000_007F, 32'h400, 1'b1, 1'b0);
    lit("ill_flag", {31'd0, out_illegal}, 32'd1);
    lit("ill_ctrl", {20'd0, out_alu_op, out_alu_src, out_reg_write, out_mem_read,
                     out_mem_write, out_mem_to_reg, out_imm_sel}, 32'd0);

    // csrrw x3,0x300,x1
    drive(1'b1, 32'h3000_91F3, 32'h404, 1'b1, 1'b0);
    lit("csr_alu_op", {28'd0, out_alu_op}, CSR_ON ? 32'd6 : 32'd0);
    lit("csr_illegal", {31'd0, out_illegal}, CSR_ON ? 32'd0 : 32'd1);
    lit("csr_reg_write", {31'd0, out_reg_write}, CSR_ON ? 32'd1 : 32'd0);

    drive(1'b1, 32'h0010_0013, 32'h408, 1'b1, 1'b0);
    lit("x0_reg_write", {31'd0, out_reg_write}, 32'd0);
    lit("x0_alu_op", {28'd0, out_alu_op}, 32'd3);

    drive(1'b1, 32'h0050_A223, 32'h40C, 1'b1, 1'b0);
    lit("sw_mem_write", {31'd0, out_mem_write}, 32'd1);
    lit("sw_imm_sel", {29'd0, out_imm_sel}, 32'd1);
    drive(1'b1, 32'h0020_8463, 32'h410, 1'b1, 1'b0);
    lit("beq_alu_op", {28'd0, out_alu_op}, 32'd1);
    lit("beq_imm_sel", {29'd0, out_imm_sel}, 32'd3);
    drive(1'b1, 32'h1234_53B7, 32'h414, 1'b1, 1'b0);
    lit("lui_alu_op", {28'd0, out_alu_op}, 32'd4);
    drive(1'b1, 32'h0000_1417, 32'h418, 1'b1, 1'b0);
    lit("auipc_alu_op", {28'd0, out_alu_op}, 32'd5);
    drive(1'b1, 32'h0080_00EF, 32'h41C, 1'b1, 1'b0);
    lit("jal_alu_op", {28'd0, out_alu_op}, 32'd7);
    lit("jal_imm_sel", {29'd0, out_imm_sel}, 32'd4);
    drive(1'b1, 32'h0000_8067, 32'h420, 1'b1, 1'b0);
    lit("jalr_imm_sel", {29'd0, out_imm_sel}, 32'd0);
    lit("jalr_reg_write", {31'd0, out_reg_write}, 32'd0);

    // Store data dependency through rs2
    drive(1'b1, 32'h0000_A283, 32'h500, 1'b1, 1'b0);
    in_instr = 32'h0050_A223;
    in_pc    = 32'h504;
    #1;
    lit("st_rs2_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge sys_clk);
    #1;
    @(posedge sys_clk);
    #1;
    lit("st_rs2_issue", {31'd0, out_mem_write}, 32'd1);

    // Load into x0 never stalls; jal has no sources
    drive(1'b1, 32'h0000_A003, 32'h510, 1'b1, 1'b0);
    in_instr = 32'h0020_0333;
    #1;
    lit("lw_x0_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h0000_A283, 32'h520, 1'b1, 1'b0);
    in_instr = 32'h0080_00EF;
    #1;
    lit("lw_jal_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge sys_clk);
    #1;

    // Saturate the stall counter with a held load-use pair
    drive(1'b1, 32'h0000_A283, 32'h600, 1'b1, 1'b0);
    in_instr  = 32'h0022_8333;
    in_pc     = 32'h604;
    out_ready = 1'b0;
    repeat (65540) @(posedge sys_clk);
    #1;
    lit("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
    lit("sat_held_pc", out_pc, 32'h600);

    // Asynchronous reset mid-operation
    #2;
    sys_rst_n = 1'b0;
    #1;
    lit("async_rst_valid", {31'd0, out_valid}, 32'd0);
    lit("async_rst_stall", {16'd0, stall_cnt}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h700, 1'b1, 1'b0);
    lit("post_rst_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
